// File: rtl/router_arbiter.sv
// 4x4 router arbiter: per-output round-robin grant with a registered output stage.
// Optional stall counter enabled by defining ROUTER_ARB_CONFLICT_CNT_EN.
module router_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0]                 in_valid,
  input  logic [3:0][DATA_WIDTH-1:0] in_data,
  input  logic [3:0][1:0]            in_dest,
  output logic [3:0]                 in_ready,
  output logic [3:0][DATA_WIDTH-1:0] out_data,
  output logic [3:0]                 out_valid,
  output logic [3:0][1:0]            out_src,
  input  logic [3:0]                 out_ready
`ifdef ROUTER_ARB_CONFLICT_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]       conflict_count
`endif
);

  logic [3:0]                 out_valid_q, out_valid_d;
  logic [3:0][DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [3:0][1:0]            out_src_q, out_src_d;
  logic [3:0][1:0]            ptr_q, ptr_d;
  logic [3:0]                 free;
  logic [3:0]                 grant;
  logic [3:0][1:0]            winner;
  logic [3:0]                 ready_c;
  logic [1:0]                 cand;

  // Scan candidates starting at ptr; the first valid requester for j wins.
  always_comb begin
    free    = '0;
    grant   = '0;
    winner  = '0;
    ready_c = '0;
    cand    = '0;
    for (int j = 0; j < 4; j++) begin
      free[j] = !out_valid_q[j] || out_ready[j];
      if (free[j]) begin
        for (int k = 0; k < 4; k++) begin
          cand = ptr_q[j] + 2'(k);
          if (!grant[j] && in_valid[cand] && (in_dest[cand] == 2'(j))) begin
            grant[j]  = 1'b1;
            winner[j] = cand;
          end
        end
      end
      if (grant[j]) ready_c[winner[j]] = 1'b1;
    end
  end

  assign in_ready = rst ? ready_c : 4'b0000;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    for (int j = 0; j < 4; j++) begin
      if (grant[j]) begin
        out_valid_d[j] = 1'b1;
        out_data_d[j]  = in_data[winner[j]];
        out_src_d[j]   = winner[j];
        ptr_d[j]       = winner[j] + 2'd1;
      end else if (free[j]) begin
        out_valid_d[j] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

`ifdef ROUTER_ARB_CONFLICT_CNT_EN
  logic [CNT_WIDTH-1:0] conflict_q, conflict_d;

  // Counts cycles in which any presented word is stalled; sticks at all-ones.
  always_comb begin
    conflict_d = conflict_q;
    if (|(in_valid & ~in_ready) && !(&conflict_q)) begin
      conflict_d = conflict_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) conflict_q <= '0;
    else      conflict_q <= conflict_d;
  end

  assign conflict_count = conflict_q;
`else
  // Counter width only matters when the counter is built.
  logic [CNT_WIDTH-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_router_arbiter.sv
// Scoreboard bench for router_arbiter; checks conflict_count when
// ROUTER_ARB_CONFLICT_CNT_EN is defined.
module tb_router_arbiter;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] src;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      in_valid;
  logic [3:0][7:0] in_data;
  logic [3:0][1:0] in_dest;
  logic [3:0]      in_ready;
  logic [3:0][7:0] out_data;
  logic [3:0]      out_valid;
  logic [3:0][1:0] out_src;
  logic [3:0]      out_ready;
`ifdef ROUTER_ARB_CONFLICT_CNT_EN
  logic [15:0]     conflict_count;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[4][$];

  router_arbiter #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_src   (out_src),
    .out_ready (out_ready)
`ifdef ROUTER_ARB_CONFLICT_CNT_EN
    ,
    .conflict_count (conflict_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // One cycle: drive after the edge, check in_ready before the next edge and
  // queue the words that the hand-computed ready pattern says are accepted.
  task automatic step(input string name, input logic rst_v, input logic [3:0] v,
                      input logic [3:0][7:0] d, input logic [3:0][1:0] dst,
                      input logic [3:0] ordy, input logic [3:0] exp_rdy);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = rst_v;
    in_valid  = v;
    in_data   = d;
    in_dest   = dst;
    out_ready = ordy;
    #3;
    chk({name, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
    for (int i = 0; i < 4; i++) begin
      if (exp_rdy[i]) begin
        e.data = d[i];
        e.src  = 2'(i);
        exp_q[dst[i]].push_back(e);
      end
    end
  endtask

  // Monitor: every valid output must match the head of its queue; pop on consume.
  always @(negedge clk) begin
    for (int j = 0; j < 4; j++) begin
      if (out_valid[j] === 1'b1) begin
        if (exp_q[j].size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_out%0d: got data %h src %0d, expected no word", j,
                   out_data[j], out_src[j]);
        end else begin
          chk($sformatf("out%0d", j), {22'd0, out_data[j], out_src[j]},
              {22'd0, exp_q[j][0].data, exp_q[j][0].src});
          if (out_ready[j] === 1'b1) void'(exp_q[j].pop_front());
        end
      end
    end
  end

  // Source-side rule: a stalled input must hold its word until accepted.
  logic [3:0]      pend_p;
  logic [3:0][7:0] data_p;
  logic [3:0][1:0] dest_p;
  initial pend_p = '0;
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (pend_p[i]) begin
        chk($sformatf("hold_in%0d", i), {22'd0, in_valid[i], in_data[i], in_dest[i]},
            {22'd0, 1'b1, data_p[i], dest_p[i]});
      end
    end
    pend_p = (rst === 1'b1) ? (in_valid & ~in_ready) : 4'b0000;
    data_p = in_data;
    dest_p = in_dest;
  end

  logic [3:0][7:0] z_d, rr_d, perm_d;
  logic [3:0][1:0] z_dst, rr_dst, perm_dst;

  initial begin
    rst       = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    in_dest   = '0;
    out_ready = 4'hF;
    z_d       = '0;
    z_dst     = '0;
    rr_d      = {8'h23, 8'h22, 8'h21, 8'h20};
    rr_dst    = {2'd1, 2'd1, 2'd1, 2'd1};
    perm_d    = {8'h13, 8'h12, 8'h11, 8'h10};
    perm_dst  = {2'd0, 2'd1, 2'd2, 2'd3};

    // Reset with every input requesting
    step("rst0", 1'b0, 4'hF, perm_d, perm_dst, 4'hF, 4'h0);
    step("rst1", 1'b0, 4'hF, perm_d, perm_dst, 4'hF, 4'h0);
    step("idle0", 1'b1, 4'h0, z_d, z_dst, 4'hF, 4'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_src", 32'(out_src), 32'h0);

    // Single transfer to output 2
    step("single", 1'b1, 4'b0001, {8'h00, 8'h00, 8'h00, 8'hA5}, {2'd0, 2'd0, 2'd0, 2'd2},
         4'hF, 4'b0001);
    // Permutation: all four accepted together
    step("perm", 1'b1, 4'hF, perm_d, perm_dst, 4'hF, 4'hF);
    chk("single_out_valid", 32'(out_valid), 32'h4);
    step("idle1", 1'b1, 4'h0, z_d, z_dst, 4'hF, 4'h0);
    chk("perm_out_valid", 32'(out_valid), 32'hF);
    chk("perm_out_data", out_data, 32'h10111213);
    step("idle2", 1'b1, 4'h0, z_d, z_dst, 4'hF, 4'h0);
    chk("drain_out_valid", 32'(out_valid), 32'h0);

    // Round-robin on output 1 from a fresh pointer, with a reset pulse mid-stream
    step("rr_rst", 1'b0, 4'h0, z_d, z_dst, 4'hF, 4'h0);
    step("rr1", 1'b1, 4'hF, rr_d, rr_dst, 4'hF, 4'b0001);
`ifdef ROUTER_ARB_CONFLICT_CNT_EN
    chk("cnt_start", 32'(conflict_count), 32'd0);
`endif
    step("rr2", 1'b1, 4'hF, rr_d, rr_dst, 4'hF, 4'b0010);
    step("rr3", 1'b1, 4'hF, rr_d, rr_dst, 4'hF, 4'b0100);
    step("rr4", 1'b1, 4'hF, rr_d, rr_dst, 4'hF, 4'b1000);
    step("rr5", 1'b1, 4'hF, rr_d, rr_dst, 4'hF, 4'b0001);
    step("rr_pulse", 1'b0, 4'hF, rr_d, rr_dst, 4'hF, 4'h0);
`ifdef ROUTER_ARB_CONFLICT_CNT_EN
    chk("cnt_after5", 32'(conflict_count), 32'd5);
`endif
    step("rr6", 1'b1, 4'hF, rr_d, rr_dst, 4'hF, 4'b0001);
    chk("rr_cleared_valid", 32'(out_valid), 32'h0);
`ifdef ROUTER_ARB_CONFLICT_CNT_EN
    chk("cnt_cleared", 32'(conflict_count), 32'd0);
`endif
    step("rr7", 1'b1, 4'hF, rr_d, rr_dst, 4'hF, 4'b0010);
    step("bp_rst", 1'b0, 4'hF, rr_d, rr_dst, 4'hF, 4'h0);

    // Backpressure on output 3
    step("bp_load", 1'b1, 4'b0001, {8'h00, 8'h00, 8'h00, 8'h55}, {2'd0, 2'd0, 2'd0, 2'd3},
         4'hF, 4'b0001);
    for (int c = 0; c < 3; c++) begin
      step("bp_stall", 1'b1, 4'b0010, {8'h00, 8'h00, 8'h66, 8'h00}, {2'd0, 2'd0, 2'd3, 2'd0},
           4'b0111, 4'b0000);
      chk("bp_held_data", 32'(out_data[3]), 32'h55);
    end
    step("bp_release", 1'b1, 4'b0010, {8'h00, 8'h00, 8'h66, 8'h00}, {2'd0, 2'd0, 2'd3, 2'd0},
         4'hF, 4'b0010);
    step("bp_idle", 1'b1, 4'h0, z_d, z_dst, 4'hF, 4'h0);
    chk("bp_out_src", 32'(out_src[3]), 32'd1);
    step("tail", 1'b1, 4'h0, z_d, z_dst, 4'hF, 4'h0);
    step("tail", 1'b1, 4'h0, z_d, z_dst, 4'hF, 4'h0);

    for (int j = 0; j < 4; j++) chk($sformatf("q%0d_empty", j), 32'(exp_q[j].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
